// File: rtl/pc_addr_unit_pkg.sv
// Shared encodings for the PC/address unit: next-PC selects, address-source selects and request FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pc_addr_unit_pkg;

  // Next-PC source select (pc_sel). Codes 6 and 7 are reserved and behave as hold.
  localparam logic [2:0] PC_ALU  = 3'd0;
  localparam logic [2:0] PC_P4   = 3'd1;
  localparam logic [2:0] PC_M4   = 3'd2;
  localparam logic [2:0] PC_OLD  = 3'd3;
  localparam logic [2:0] PC_TRAP = 3'd4;
  localparam logic [2:0] PC_EPC  = 3'd5;

  // Memory address source select (mem_sel).
  localparam logic MEM_PC  = 1'b0;
  localparam logic MEM_ALU = 1'b1;

  // Memory request FSM state codes.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/pc_addr_unit_addr_req_fsm.sv
// Memory request tracker: latches the access address and holds mem_req until the grant arrives.
// Latency: mem_req rises the cycle after acc_start; done pulses the cycle after mem_gnt.
// Backpressure: while busy, acc_start is ignored (no queuing); mem_gnt is ignored while idle.
//
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   acc_start  begin an access using addr (sampled only when idle)
//   mem_gnt    grant for the outstanding request
//   addr       address to latch at acc_start
//   mem_addr   latched address, stable while mem_req=1
//   mem_req    request outstanding
//   busy       same as mem_req; used by the top to freeze the PC
//   done       one-cycle pulse the cycle after the grant
module pc_addr_unit_addr_req_fsm
  import pc_addr_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            acc_start,
  input  logic            mem_gnt,
  input  logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_req,
  output logic            busy,
  output logic            done
);

  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (rst) begin
      // A reset mid-access drops the request silently: no done pulse.
      state    <= ST_IDLE;
      mem_addr <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (acc_start) begin
            state    <= ST_BUSY;
            mem_addr <= addr;
          end
        end
        ST_BUSY: begin
          if (mem_gnt) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_req = (state == ST_BUSY);
  assign busy    = mem_req;

endmodule

// File: rtl/pc_addr_unit.sv
// PC and address generator: PC/EPC registers, 6-way next-PC select, misaligned-jump trap redirect, memory request handshake.
// Latency: pc/epc/misalign update 1 cycle after pc_en; addr is combinational; mem_req 1 cycle after acc_start.
// Backpressure: while a memory request is outstanding (busy) pc_en is ignored and the PC holds; nothing is queued.
//
// Ports:
//   clk, rst   clock (rising edge), synchronous active-high reset
//   pc_en      apply pc_sel this cycle (only when not busy)
//   pc_sel     next-PC source, see pc_addr_unit_pkg
//   mem_sel    address source: MEM_PC or MEM_ALU
//   alu_out    ALU-computed address / jump target
//   acc_start  start a memory access at the current addr
//   mem_gnt    grant for the outstanding request
//   pc, epc    current PC and saved exception PC
//   addr       combinational mem_sel ? alu_out : pc
//   mem_addr   latched request address
//   mem_req    request outstanding; busy mirrors it
//   done       one-cycle pulse after grant
//   misalign   one-cycle pulse after an ALU jump to a misaligned target
module pc_addr_unit
  import pc_addr_unit_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = 'h100,
  parameter int              STEP       = 4,
  parameter int              ALIGN_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en,
  input  logic [2:0]      pc_sel,
  input  logic            mem_sel,
  input  logic [XLEN-1:0] alu_out,
  input  logic            acc_start,
  input  logic            mem_gnt,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] addr,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_req,
  output logic            busy,
  output logic            done,
  output logic            misalign
);

  // Low bits that must be zero on an ALU jump; ALIGN_BITS=0 yields an empty mask and disables the check.
  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << ALIGN_BITS);
  localparam logic [XLEN-1:0] STEP_V     = XLEN'(STEP);

  logic            pc_upd;
  logic            alu_misaligned;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] epc_nxt;
  logic            misalign_nxt;

  assign pc_upd         = pc_en && !busy;
  assign alu_misaligned = |(alu_out & ALIGN_MASK);

  always_comb begin
    pc_nxt       = pc;
    epc_nxt      = epc;
    misalign_nxt = 1'b0;
    if (pc_upd) begin
      case (pc_sel)
        PC_ALU: begin
          if (alu_misaligned) begin
            pc_nxt       = TRAP_VEC;
            epc_nxt      = pc;
            misalign_nxt = 1'b1;
          end else begin
            pc_nxt = alu_out;
          end
        end
        // Both directions wrap modulo 2^XLEN by plain overflow.
        PC_P4:   pc_nxt = pc + STEP_V;
        PC_M4:   pc_nxt = pc - STEP_V;
        PC_TRAP: begin
          pc_nxt  = TRAP_VEC;
          epc_nxt = pc;
        end
        PC_EPC:  pc_nxt = epc;
        default: pc_nxt = pc;  // PC_OLD and reserved codes hold
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_VEC;
      epc      <= '0;
      misalign <= 1'b0;
    end else begin
      pc       <= pc_nxt;
      epc      <= epc_nxt;
      misalign <= misalign_nxt;
    end
  end

  // Request address is taken from the pre-update pc when pc_en lands in the same cycle.
  assign addr = (mem_sel == MEM_ALU) ? alu_out : pc;

  pc_addr_unit_addr_req_fsm #(
    .XLEN (XLEN)
  ) u_addr_req_fsm (
    .clk       (clk),
    .rst       (rst),
    .acc_start (acc_start),
    .mem_gnt   (mem_gnt),
    .addr      (addr),
    .mem_addr  (mem_addr),
    .mem_req   (mem_req),
    .busy      (busy),
    .done      (done)
  );

endmodule

// File: tb/tb_pc_addr_unit.sv
// Scoreboard bench for pc_addr_unit: a driver applies directed then random stimulus and pushes the
// outputs expected for each cycle (from a behavioural model) into a queue; a monitor pops and compares.
// Latency: n/a. Backpressure: n/a.
module tb_pc_addr_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_en = 1'b0;
  logic [2:0]  pc_sel = 3'd3;
  logic        mem_sel = 1'b0;
  logic [31:0] alu_out = '0;
  logic        acc_start = 1'b0;
  logic        mem_gnt = 1'b0;
  logic [31:0] pc, epc, addr, mem_addr;
  logic        mem_req, busy, done, misalign;

  always #5 clk = ~clk;

  pc_addr_unit dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .pc_sel(pc_sel), .mem_sel(mem_sel),
    .alu_out(alu_out), .acc_start(acc_start), .mem_gnt(mem_gnt),
    .pc(pc), .epc(epc), .addr(addr), .mem_addr(mem_addr),
    .mem_req(mem_req), .busy(busy), .done(done), .misalign(misalign)
  );

  typedef struct {
    logic [31:0] pc, epc, addr, maddr;
    logic        req, dn, mis;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Behavioural model state: the architectural values as described, not the RTL structure.
  logic [31:0] m_pc, m_epc, m_maddr;
  bit          m_busy, m_done, m_mis;
  bit          m_known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got 'h%0h, expected 'h%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: compares DUT outputs on the falling edge whenever an expectation is waiting.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc",       pc,       e.pc);
        chk("epc",      epc,      e.epc);
        chk("addr",     addr,     e.addr);
        chk("mem_addr", mem_addr, e.maddr);
        chk("mem_req",  {31'd0, mem_req},  {31'd0, e.req});
        chk("busy",     {31'd0, busy},     {31'd0, e.req});
        chk("done",     {31'd0, done},     {31'd0, e.dn});
        chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
      end
    end
  end

  // One clock cycle of stimulus: drive inputs just after the edge, record what the DUT should
  // show this cycle, then advance the model to the state after the next edge.
  task automatic cyc(input bit r, input bit en, input logic [2:0] sel, input bit ms,
                     input logic [31:0] alu, input bit acc, input bit gnt);
    exp_t e;
    logic [31:0] n_pc, n_epc, n_maddr;
    bit n_busy, n_done, n_mis;
    @(posedge clk);
    #1;
    rst = r; pc_en = en; pc_sel = sel; mem_sel = ms; alu_out = alu; acc_start = acc; mem_gnt = gnt;
    if (m_known) begin
      e.pc = m_pc; e.epc = m_epc; e.maddr = m_maddr;
      e.addr = ms ? alu : m_pc;
      e.req = m_busy; e.dn = m_done; e.mis = m_mis;
      q.push_back(e);
    end
    if (r) begin
      m_pc = 32'h0; m_epc = 32'h0; m_maddr = 32'h0;
      m_busy = 0; m_done = 0; m_mis = 0; m_known = 1;
    end else if (m_known) begin
      n_pc = m_pc; n_epc = m_epc; n_maddr = m_maddr;
      n_busy = m_busy; n_done = 0; n_mis = 0;
      if (!m_busy) begin
        if (en) begin
          case (sel)
            3'd0: if (alu % 4 != 0) begin n_pc = 32'h100; n_epc = m_pc; n_mis = 1; end
                  else n_pc = alu;
            3'd1: n_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
            3'd2: n_pc = 32'((64'(m_pc) + 64'h1_0000_0000 - 64'd4) % 64'h1_0000_0000);
            3'd4: begin n_pc = 32'h100; n_epc = m_pc; end
            3'd5: n_pc = m_epc;
            default: ;
          endcase
        end
        if (acc) begin n_busy = 1; n_maddr = ms ? alu : m_pc; end
      end else if (gnt) begin
        n_busy = 0; n_done = 1;
      end
      m_pc = n_pc; m_epc = n_epc; m_maddr = n_maddr;
      m_busy = n_busy; m_done = n_done; m_mis = n_mis;
    end
  endtask

  localparam logic [2:0] S_ALU = 3'd0, S_P4 = 3'd1, S_M4 = 3'd2, S_OLD = 3'd3,
                         S_TRAP = 3'd4, S_EPC = 3'd5;

  initial begin
    int budget;
    // Reset then step forward: pc 0,4,8,'hC.
    cyc(1, 0, S_OLD, 0, 0, 0, 0);
    cyc(1, 0, S_OLD, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, S_P4, 0, 0, 0, 0);
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    // Wrap below zero and back.
    cyc(1, 0, S_OLD, 0, 0, 0, 0);
    cyc(0, 1, S_M4, 0, 0, 0, 0);
    cyc(0, 1, S_P4, 0, 0, 0, 0);
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    // Misaligned ALU jump traps, EPC return restores.
    cyc(0, 1, S_ALU, 0, 32'h40, 0, 0);
    cyc(0, 1, S_ALU, 0, 32'h202, 0, 0);
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    cyc(0, 1, S_EPC, 0, 0, 0, 0);
    cyc(0, 1, S_TRAP, 0, 0, 0, 0);
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    // Access from the ALU address; PC frozen while waiting for the grant.
    cyc(0, 0, S_OLD, 1, 32'h800, 1, 0);
    repeat (3) cyc(0, 1, S_P4, 1, 32'h900, 1, 0);
    cyc(0, 1, S_P4, 0, 0, 0, 1);
    cyc(0, 0, S_OLD, 0, 0, 1, 0);        // new request on the done cycle
    cyc(0, 0, S_OLD, 0, 0, 0, 1);
    cyc(0, 0, S_OLD, 0, 0, 0, 1);        // grant while idle is ignored
    // Simultaneous pc_en and acc_start: request uses the old pc.
    cyc(0, 1, S_ALU, 0, 32'h10, 0, 0);
    cyc(0, 1, S_P4, 0, 0, 1, 0);
    cyc(0, 0, S_OLD, 0, 0, 0, 1);
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    // Reset in the middle of an access.
    cyc(0, 0, S_OLD, 1, 32'h500, 1, 0);
    cyc(0, 1, S_P4, 0, 0, 0, 0);
    cyc(1, 0, S_OLD, 0, 0, 0, 1);
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    // Top-of-range wrap upward.
    cyc(0, 1, S_ALU, 0, 32'hFFFF_FFF8, 0, 0);
    repeat (3) cyc(0, 1, S_P4, 0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(1, 0) == 1) a[1:0] = 2'b00;
      cyc($urandom_range(99, 0) == 0, $urandom_range(1, 0) == 1, 3'($urandom_range(7, 0)),
          $urandom_range(1, 0) == 1, a, $urandom_range(9, 0) < 3, $urandom_range(9, 0) < 4);
    end
    cyc(0, 0, S_OLD, 0, 0, 0, 0);
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
